// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter between two byte-stream requesters.
//            Arbitration is round-robin and per message: once granted, a
//            requester keeps the transmitter until it hands over a byte with
//            tlast. The output toward the transmitter is a registered
//            valid/ready stage.
// Revision : 1.0 - initial release
//
// Ports
//   clk              rising-edge clock (transmitter domain)
//   rst              asynchronous reset, active low
//   reqN_tdata/tvalid/tlast  requester N byte stream in (N = 0, 1)
//   reqN_tready      requester N byte accepted this cycle
//   tx_tdata/tvalid  registered byte stream to the transmitter
//   tx_tready        transmitter accepts the byte
//   grant            one-hot current owner, 00 = none
//   timeout          one-cycle pulse when a grant is revoked by timeout
//
// Build option
//   UART_ARB_TIMEOUT_EN : when defined, an owner that stays idle for
//   LOCK_TIMEOUT cycles inside a message loses its grant. When undefined
//   the grant is held until tlast and timeout is tied low.
// ============================================================================
module uart_tx_arbiter #(
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TW           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req0_tdata,
  input  logic       req0_tvalid,
  input  logic       req0_tlast,
  output logic       req0_tready,
  input  logic [7:0] req1_tdata,
  input  logic       req1_tvalid,
  input  logic       req1_tlast,
  output logic       req1_tready,
  output logic [7:0] tx_tdata,
  output logic       tx_tvalid,
  input  logic       tx_tready,
  output logic [1:0] grant,
  output logic       timeout
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_grant;
  logic [1:0] w_grant_nxt;
  logic       r_last_grant;      // index of the most recent winner
  logic       w_last_grant_nxt;
  logic [7:0] r_tx_tdata;
  logic       r_tx_tvalid;

  logic       w_slot_free;
  logic       w_lock;
  logic       w_own_sel;
  logic       w_own_valid;
  logic       w_own_last;
  logic [7:0] w_own_data;
  logic       w_xfer;
  logic       w_pick;
  logic       w_to_hit;

  // A range-violating timeout would make the counter compare unreachable.
  if ((LOCK_TIMEOUT < 1) || (64'(LOCK_TIMEOUT) >= (64'd1 << TW))) begin : g_bad_cfg
  end

  // The output register can take a new byte when empty or draining now.
  assign w_slot_free = ~r_tx_tvalid | tx_tready;
  assign w_lock      = (r_state == S_LOCK);

  // Owner-side mux; grant is one-hot, so bit 1 selects requester 1.
  assign w_own_sel   = r_grant[1];
  assign w_own_valid = w_own_sel ? req1_tvalid : req0_tvalid;
  assign w_own_last  = w_own_sel ? req1_tlast  : req0_tlast;
  assign w_own_data  = w_own_sel ? req1_tdata  : req0_tdata;

  assign req0_tready = w_lock & r_grant[0] & w_slot_free;
  assign req1_tready = w_lock & r_grant[1] & w_slot_free;
  assign w_xfer      = w_lock & w_own_valid & w_slot_free;

  // On a tie the requester that did not win last time takes the grant.
  assign w_pick = (req0_tvalid & req1_tvalid) ? ~r_last_grant : req1_tvalid;

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      S_IDLE: begin
        if (req0_tvalid | req1_tvalid) begin
          w_state_nxt      = S_LOCK;
          w_grant_nxt      = w_pick ? 2'b10 : 2'b01;
          w_last_grant_nxt = w_pick;
        end
      end
      S_LOCK: begin
        if ((w_xfer & w_own_last) | w_to_hit) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = 2'b00;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 2'b00;
      r_last_grant <= 1'b1;
      r_tx_tdata   <= 8'h00;
      r_tx_tvalid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      if (w_xfer) begin
        r_tx_tdata  <= w_own_data;
        r_tx_tvalid <= 1'b1;
      end else if (tx_tready) begin
        r_tx_tvalid <= 1'b0;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [TW-1:0] r_cnt;
  logic          r_timeout;
  logic          w_idle_cyc;

  // Only cycles where the owner offers nothing count; transmitter stalls
  // with the owner still valid do not.
  assign w_idle_cyc = w_lock & ~w_own_valid;
  assign w_to_hit   = w_idle_cyc & (r_cnt == TW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_hit;
      // Held at zero in IDLE so every new lock starts from a clean count.
      if (!w_lock || w_xfer || w_to_hit) begin
        r_cnt <= '0;
      end else if (w_idle_cyc) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign tx_tdata  = r_tx_tdata;
  assign tx_tvalid = r_tx_tvalid;
  assign grant     = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter. Two queue-fed
//            requester drivers and an output byte logger run beside a
//            scripted sequence of directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req0_tdata = 8'h00;
  logic       req0_tvalid = 1'b0;
  logic       req0_tlast = 1'b0;
  logic       req0_tready;
  logic [7:0] req1_tdata = 8'h00;
  logic       req1_tvalid = 1'b0;
  logic       req1_tlast = 1'b0;
  logic       req1_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tready = 1'b1;
  logic [1:0] grant;
  logic       timeout;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Requester queues hold {tlast, tdata}; the logger keeps accepted bytes.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       en0 = 1'b0;
  logic       en1 = 1'b0;
  logic [7:0] txq[$];
  int         txc[$];

  uart_tx_arbiter #(
    .LOCK_TIMEOUT(8),
    .TW          (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_tdata (req0_tdata),
    .req0_tvalid(req0_tvalid),
    .req0_tlast (req0_tlast),
    .req0_tready(req0_tready),
    .req1_tdata (req1_tdata),
    .req1_tvalid(req1_tvalid),
    .req1_tlast (req1_tlast),
    .req1_tready(req1_tready),
    .tx_tdata   (tx_tdata),
    .tx_tvalid  (tx_tvalid),
    .tx_tready  (tx_tready),
    .grant      (grant),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Handshakes are sampled mid-cycle; inputs change 2 time units after the
  // edge so the script (acting at +1) can queue bytes for the same cycle.
  initial begin : drv
    logic h0;
    logic h1;
    forever begin
      @(negedge clk);
      h0 = req0_tvalid & req0_tready;
      h1 = req1_tvalid & req1_tready;
      if (tx_tvalid & tx_tready) begin
        txq.push_back(tx_tdata);
        txc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      #2;
      if (h0 && q0.size() != 0) q0.delete(0);
      if (h1 && q1.size() != 0) q1.delete(0);
      req0_tvalid = en0 && (q0.size() != 0);
      {req0_tlast, req0_tdata} = (q0.size() != 0) ? q0[0] : 9'h000;
      req1_tvalid = en1 && (q1.size() != 0);
      {req1_tlast, req1_tdata} = (q1.size() != 0) ? q1[0] : 9'h000;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : script
    int         k;
    int         pulses;
    int         tpos;
    int         c0;
    int         c1;
    logic [7:0] e1[6];
    logic [7:0] e4[3];
    logic [1:0] gl[$];

    // Reset values
    step(3);
    chk("rst_grant", grant, 2'b00);
    chk("rst_tvalid", tx_tvalid, 1'b0);
    chk("rst_tdata", tx_tdata, 8'h00);
    chk("rst_timeout", timeout, 1'b0);
    rst = 1'b1;
    step(1);

    // Simultaneous 3-byte messages: tie to requester 0, one idle gap
    txq.delete();
    txc.delete();
    q0 = '{9'h0A0, 9'h0A1, 9'h1A2};
    q1 = '{9'h0B0, 9'h0B1, 9'h1B2};
    en0 = 1'b1;
    en1 = 1'b1;
    step(1);
    chk("t1_grant", grant, 2'b01);
    step(10);
    chk("t1_count", txq.size(), 6);
    e1 = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
    if (txq.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t1_byte", txq[i], e1[i]);
      chk("t1_span_a", txc[2] - txc[0], 2);
      chk("t1_gap_ab", txc[3] - txc[2], 2);
      chk("t1_span_b", txc[5] - txc[3], 2);
    end

    // Fairness with single-byte messages
    txq.delete();
    gl.delete();
    for (int i = 0; i < 10; i++) begin
      q0.push_back({1'b1, 8'(8'h10 + i)});
      q1.push_back({1'b1, 8'(8'h20 + i)});
    end
    for (int i = 0; i < 44; i++) begin
      step(1);
      if (grant != 2'b00) gl.push_back(grant);
    end
    chk("t2_grants", gl.size(), 20);
    if (gl.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t2_alt", gl[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    c0 = 0;
    c1 = 0;
    foreach (txq[i]) begin
      if (txq[i][7:4] == 4'h1) c0++;
      if (txq[i][7:4] == 4'h2) c1++;
    end
    chk("t2_cnt0", c0, 10);
    chk("t2_cnt1", c1, 10);
    chk("t2_balance", ((c0 - c1) <= 1 && (c1 - c0) <= 1) ? 1 : 0, 1);

    // Backpressure: byte held stable while the transmitter stalls
    txq.delete();
    en1 = 1'b0;
    tx_tready = 1'b0;
    q0.push_back(9'h055);
    q0.push_back(9'h1AA);
    k = 0;
    step(1);
    while (!tx_tvalid && k < 10) begin
      step(1);
      k++;
    end
    chk("t3_load", tx_tvalid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("t3_hold_data", tx_tdata, 8'h55);
      chk("t3_hold_valid", tx_tvalid, 1'b1);
      chk("t3_stall_rdy", req0_tready, 1'b0);
      if (i < 4) step(1);
    end
    tx_tready = 1'b1;
    #1;
    chk("t3_rdy_back", req0_tready, 1'b1);
    step(1);
    chk("t3_next_data", tx_tdata, 8'hAA);
    chk("t3_next_valid", tx_tvalid, 1'b1);
    step(3);

    // Interleave attempt inside a message
    txq.delete();
    q0.push_back(9'h001);
    en0 = 1'b1;
    en1 = 1'b0;
    step(2);
    chk("t4_first", tx_tdata, 8'h01);
    q1.push_back(9'h102);
    en1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      #2;
      chk("t4_grant_held", grant, 2'b01);
      chk("t4_rdy1_low", req1_tready, 1'b0);
    end
    q0.push_back(9'h103);
    step(5);
    chk("t4_count", txq.size(), 3);
    e4 = '{8'h01, 8'h03, 8'h02};
    if (txq.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t4_order", txq[i], e4[i]);
    end

    // Idle owner inside a message
    txq.delete();
    en1 = 1'b1;
    q0.push_back(9'h010);
    step(2);
    chk("t5_load", tx_tdata, 8'h10);
    q1.push_back(9'h111);
    pulses = 0;
    tpos = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (timeout) begin
        pulses++;
        if (tpos == 0) tpos = i;
      end
`ifdef UART_ARB_TIMEOUT_EN
      if (i == 8) chk("t5_revoked", grant, 2'b00);
      if (i == 9) chk("t5_regrant", grant, 2'b10);
`endif
    end
`ifdef UART_ARB_TIMEOUT_EN
    chk("t5_pulses", pulses, 1);
    chk("t5_pulse_pos", tpos, 8);
`else
    chk("t5_grant_kept", grant, 2'b01);
    chk("t5_pulses", pulses, 0);
    q0.push_back(9'h112);
`endif
    step(6);

    // Asynchronous reset mid-message
    q0 = '{9'h021, 9'h022, 9'h123};
    q1 = '{9'h131};
    en0 = 1'b1;
    en1 = 1'b1;
    step(2);
    chk("t6_pre_valid", tx_tvalid, 1'b1);
    chk("t6_pre_grant", grant, 2'b01);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_valid", tx_tvalid, 1'b0);
    chk("t6_async_grant", grant, 2'b00);
    q0.delete();
    q1.delete();
    q0.push_back(9'h140);
    q1.push_back(9'h150);
    step(1);
    rst = 1'b1;
    step(1);
    chk("t6_tie_after_rst", grant, 2'b01);
    step(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
